// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexed scan controller for a four-digit 7-segment display. It
// produces the 2-bit mux select and the matching one-hot digit enable, lights
// each enabled digit for PRESCALE cycles in rotation, and pulses frame_tick
// whenever the rotation wraps back to a lower (or the same) index.
//
// Optional feature macro: SCAN_BLANKING_EN
//   defined   -> a BLANK state holds all digits dark for BLANK_CYCLES cycles
//                between consecutive slots (anti-ghosting).
//   undefined -> slots run back-to-back; BLANK_CYCLES is not used by logic.
// -----------------------------------------------------------------------------
module display_scanner #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    output logic [1:0] select,
    output logic [3:0] digit_en,
    output logic       frame_tick
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [3:0] EN_IDLE = (ACTIVE_LOW != 0) ? 4'b1111 : 4'b0000;

`ifdef SCAN_BLANKING_EN
    // One counter serves both the show slot and the blanking gap.
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
`else
    localparam int CNT_MAX = PRESCALE;
`endif
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
`ifdef SCAN_BLANKING_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1
`ifdef SCAN_BLANKING_EN
        ,
        ST_BLANK = 2'd2
`endif
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       select_q;
    logic [3:0]       digit_en_q;
    logic             frame_tick_q;

    // Combinational helpers feeding the state register.
    logic             mask_any_d;
    logic [1:0]       first_sel_d;
    logic [1:0]       next_sel_d;
    logic             wrap_d;
    logic             slot_done_d;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Digit-enable pattern for a given index, in the configured polarity.
    function automatic logic [3:0] enc(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        return (ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    // First index after cur (mod 4) whose mask bit is set; cur itself is the
    // last candidate, so a single enabled digit selects itself again.
    function automatic logic [1:0] next_from(input logic [1:0] cur,
                                             input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Next-digit search and end-of-slot detection
    // -------------------------------------------------------------------------

    // Derive the candidate indices and the slot-end condition for this cycle.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // can leave it unassigned and infer a latch.
        mask_any_d  = |digit_mask;
        // Searching from index 3 visits 0,1,2,3: the lowest set bit.
        first_sel_d = next_from(2'd3, digit_mask);
        next_sel_d  = next_from(select_q, digit_mask);
        wrap_d      = (next_sel_d <= select_q);
        slot_done_d = 1'b0;
`ifdef SCAN_BLANKING_EN
        if (state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
            slot_done_d = 1'b1;
        end
`else
        if (state_q == ST_SHOW && cnt_q == SHOW_LAST) begin
            slot_done_d = 1'b1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Scan FSM with registered outputs
    // -------------------------------------------------------------------------

    // Sequence IDLE -> SHOW (-> BLANK) -> SHOW ..., driving select/enables.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, matching the hardware.
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            select_q     <= 2'd0;
            digit_en_q   <= EN_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;

            if (!enable) begin
                // Abort whatever slot is running and park in IDLE.
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                select_q   <= 2'd0;
                digit_en_q <= EN_IDLE;
            end else if (slot_done_d) begin
                // Advance: the mask is sampled only here.
                cnt_q <= '0;
                if (mask_any_d) begin
                    state_q      <= ST_SHOW;
                    select_q     <= next_sel_d;
                    digit_en_q   <= enc(next_sel_d);
                    frame_tick_q <= wrap_d;
                end else begin
                    state_q    <= ST_IDLE;
                    select_q   <= 2'd0;
                    digit_en_q <= EN_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (mask_any_d) begin
                            // Entry from IDLE never counts as a wrap.
                            state_q    <= ST_SHOW;
                            cnt_q      <= '0;
                            select_q   <= first_sel_d;
                            digit_en_q <= enc(first_sel_d);
                        end
                    end

                    ST_SHOW: begin
`ifdef SCAN_BLANKING_EN
                        if (cnt_q == SHOW_LAST) begin
                            // Go dark but keep select so the mux stays put.
                            state_q    <= ST_BLANK;
                            cnt_q      <= '0;
                            digit_en_q <= EN_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`else
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end

`ifdef SCAN_BLANKING_EN
                    ST_BLANK: begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif

                    default: begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        select_q   <= 2'd0;
                        digit_en_q <= EN_IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign select     = select_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------

    // Parameters must describe a usable scan.
    param_legal_a: assert property (@(posedge clk) disable iff (reset)
        (PRESCALE >= 2) && (BLANK_CYCLES >= 1));

    // The lit digit, if any, is always the one the mux is steering.
    en_matches_select_a: assert property (@(posedge clk) disable iff (reset)
        (digit_en == EN_IDLE) || (digit_en == enc(select)));

    // A wrap tick lands on the first cycle of a lit slot.
    tick_on_lit_slot_a: assert property (@(posedge clk) disable iff (reset)
        frame_tick |-> (digit_en != EN_IDLE));

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan controller for the four-digit 7-segment display. It is the decode side of the 4-to-1 segment multiplexer. It generates the 2-bit `select` that steers the mux, and turns that same index into one-hot digit enables. Each enabled digit is lit for a programmable number of clock cycles, in rotation. It sits between the display data path and the board's digit-enable pins.

## Interface
Parameters:
- `PRESCALE`, 50000: on-time of each digit in clock cycles; legal range ≥ 2.
- `BLANK_CYCLES`, 16: dead-time between digits in cycles; legal range ≥ 1; used only when `SCAN_BLANKING_EN` is defined.
- `ACTIVE_LOW`, 1: 1 means digit enables are active-low; 0 means active-high.

Ports:
- `clk`  in  1: the block's only clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: 1 runs the scan; 0 forces idle.
- `digit_mask`  in  4: bit i = 1 means digit i takes part in the scan.
- `select`  out  2: index of the current digit; drives the mux select.
- `digit_en`  out  4: one-hot digit enable, polarity set by `ACTIVE_LOW`.
- `frame_tick`  out  1: one-cycle pulse each time the scan wraps.

## Operation
- Inactive level of `digit_en`: 4'b1111 when `ACTIVE_LOW`=1, 4'b0000 otherwise.
- All outputs are registered.
- Reset values: state IDLE, `select`=0, `digit_en` inactive, `frame_tick`=0, prescale counter 0.
- FSM states: IDLE, SHOW, BLANK. BLANK exists only with `SCAN_BLANKING_EN`.
- "Next digit": the first index after `select`, counting modulo 4, whose `digit_mask` bit is 1. The search includes `select` itself as the last candidate.
- IDLE:
  - `digit_en` inactive, `select`=0.
  - If `enable`=1 and `digit_mask`≠0 at a rising edge, go to SHOW.
  - On entry to SHOW, `select` = lowest set bit of `digit_mask` and the counter is cleared.
- SHOW:
  - `digit_en` asserts bit `select` only.
  - The counter increments every cycle.
  - At counter = PRESCALE−1, the slot ends:
    - With the macro: go to BLANK.
    - Without the macro: go directly to SHOW on the next digit, counter cleared.
- BLANK:
  - `digit_en` inactive and `select` held.
  - After BLANK_CYCLES cycles, go to SHOW on the next digit.
- `digit_mask` is sampled only when a digit advances. A digit whose mask bit clears mid-slot still completes its slot.
- If `digit_mask`=0 at an advance, go to IDLE.
- `frame_tick` is 1 for exactly the first cycle after an advance in which the new `select` ≤ the old `select` (a wrap).
  - With a single enabled digit, every advance is a wrap.
  - Entry from IDLE does not tick.
- `enable`=0 at any rising edge: go to IDLE on that edge and abort the current slot. The response follows the IDLE rules (`digit_en` inactive, `select`=0).
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Latency from enable: with `enable` sampled 1 at edge k, `digit_en` is active from edge k until edge k+PRESCALE.
- Per-digit period: PRESCALE cycles; PRESCALE+BLANK_CYCLES with the macro.
- `select` and `digit_en` change on the same edge. There is never a cycle where `digit_en` selects a digit other than `select`.
- Refresh period: N × per-digit period, where N is the number of set bits in `digit_mask`.
- `frame_tick` is coincident with the first cycle of the wrapped-to digit.

## Configuration
- `SCAN_BLANKING_EN` defined:
  - The BLANK state is compiled in.
  - `digit_en` is inactive for BLANK_CYCLES cycles between every pair of consecutive slots. This suppresses ghosting.
- `SCAN_BLANKING_EN` undefined:
  - No BLANK state and no blanking counter logic.
  - Slots are back-to-back and `BLANK_CYCLES` is ignored.

## Test plan
All scenarios use PRESCALE=4, BLANK_CYCLES=2, ACTIVE_LOW=1.

- Reset, then `enable`=0: `digit_en`=1111, `select`=0, `frame_tick`=0 indefinitely.
- No macro, `digit_mask`=1111, `enable`=1: `select` steps 0,1,2,3,0 at 4 cycles each.
  - `digit_en` follows 1110, 1101, 1011, 0111.
  - `frame_tick` is a single cycle with the return to `select`=0, every 16 cycles.
- No macro, `digit_mask`=0101: `select` alternates 0,2,0.
  - `frame_tick` every 8 cycles.
  - Switching the mask to 1000 mid-slot finishes the current slot, then shows digit 3 alone with a tick every 4 cycles.
- Macro defined, `digit_mask`=0011: sequence is 1110 ×4, 1111 ×2, 1101 ×4, 1111 ×2, repeating; `select` is held during blanking.
- Drop `enable` on cycle 2 of a slot: on the next edge `digit_en`=1111 and `select`=0.
  - With `enable`=1 and `digit_mask`=0000, the block stays in IDLE.
- Assert `reset` between clock edges mid-SHOW: `digit_en`=1111 and `select`=0 before the next edge.
  - After release, the scan restarts at the lowest enabled digit with a full 4-cycle slot.
